// File: rtl/count_seq_checker.sv
// Sampling checker for a free-running counter stream: locks onto the sequence,
// flags every enabled sample that is not last+1, and keeps saturating statistics.
module count_seq_checker #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              err,
  output logic              sticky_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [WIDTH-1:0]    last_inc;
  logic                seq_ok;
  logic                locked_d, err_d, sticky_d;
  logic [ERR_W-1:0]    err_cnt_d, err_base;
  logic [WRAP_W-1:0]   wrap_cnt_d, wrap_base;

  assign last_inc = last_q + WIDTH'(1);
  assign seq_ok   = (count_in == last_inc);

  // Clear zeroes the statistics first, so a coincident mismatch or wrap
  // increments from zero and the event wins over the clear.
  assign err_base  = clr ? '0 : err_cnt;
  assign wrap_base = clr ? '0 : wrap_cnt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    last_d     = last_q;
    locked_d   = locked;
    err_d      = 1'b0;
    sticky_d   = clr ? 1'b0 : sticky_err;
    err_cnt_d  = err_base;
    wrap_cnt_d = wrap_base;

    if (en) begin
      last_d = count_in;
      unique case (state_q)
        IDLE: begin
          state_d  = ACQ;
          locked_d = 1'b0;
        end
        ACQ: begin
          if (seq_ok) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
        LOCKED: begin
          if (seq_ok) begin
            if (last_q == '1)
              wrap_cnt_d = (wrap_base == '1) ? wrap_base : wrap_base + WRAP_W'(1);
          end else begin
            state_d   = ACQ;
            locked_d  = 1'b0;
            err_d     = 1'b1;
            sticky_d  = 1'b1;
            err_cnt_d = (err_base == '1) ? err_base : err_base + ERR_W'(1);
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      sticky_err <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      locked     <= locked_d;
      err        <= err_d;
      sticky_err <= sticky_d;
      err_cnt    <= err_cnt_d;
      wrap_cnt   <= wrap_cnt_d;
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker; a second instance with ERR_W=2
// shares the stimulus and is inspected only for error-count saturation.
module tb_count_seq_checker;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [3:0]  count_in;
  logic        locked, err, sticky_err;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_cnt;
  logic        locked_s, err_s, sticky_s;
  logic [1:0]  err_cnt_s;
  logic [15:0] wrap_cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(4), .ERR_W(8), .WRAP_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .count_in(count_in),
    .locked(locked), .err(err), .sticky_err(sticky_err),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  count_seq_checker #(.WIDTH(4), .ERR_W(2), .WRAP_W(16)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .count_in(count_in),
    .locked(locked_s), .err(err_s), .sticky_err(sticky_s),
    .err_cnt(err_cnt_s), .wrap_cnt(wrap_cnt_s)
  );

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic e, input logic [3:0] c, input logic cl, input logic r);
    en = e; count_in = c; clr = cl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b1, 4'd7, 1'b1, 1'b1);
    cyc(1'b1, 4'd8, 1'b0, 1'b1);
    checks++;
    if ({locked, err, sticky_err, err_cnt, wrap_cnt} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got locked=%b err=%b sticky=%b err_cnt=%0d wrap_cnt=%0d, want all 0",
               locked, err, sticky_err, err_cnt, wrap_cnt);
    end
  endtask

  task automatic test_count();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 4'(i), 1'b0, 1'b0);
      if (err) pulses++;
      if (i == 0) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++; $display("FAIL count_unlocked_after_first: got %b want 0", locked);
        end
      end
      if (i == 1) begin
        checks++;
        if (locked !== 1'b1) begin
          failures++; $display("FAIL count_lock_at_1: got %b want 1", locked);
        end
      end
      if (i == 15) begin
        checks++;
        if (wrap_cnt !== 16'd0) begin
          failures++; $display("FAIL count_wrap_before: got %0d want 0", wrap_cnt);
        end
      end
      if (i == 16) begin
        checks++;
        if (wrap_cnt !== 16'd1) begin
          failures++; $display("FAIL count_wrap_at_0: got %0d want 1", wrap_cnt);
        end
      end
    end
    checks++;
    if (pulses !== 0 || err_cnt !== 8'd0 || locked !== 1'b1 || wrap_cnt !== 16'd1) begin
      failures++;
      $display("FAIL count_end: pulses=%0d err_cnt=%0d locked=%b wrap=%0d, want 0 0 1 1",
               pulses, err_cnt, locked, wrap_cnt);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    cyc(1'b1, 4'd8, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0 || locked !== 1'b1) begin
      failures++; $display("FAIL mm_before: err=%b locked=%b, want 0 1", err, locked);
    end
    cyc(1'b1, 4'd10, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1 || sticky_err !== 1'b1) begin
      failures++;
      $display("FAIL mm_skip: err=%b locked=%b err_cnt=%0d sticky=%b, want 1 0 1 1",
               err, locked, err_cnt, sticky_err);
    end
    cyc(1'b1, 4'd11, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0 || locked !== 1'b1) begin
      failures++; $display("FAIL mm_relock: err=%b locked=%b, want 0 1", err, locked);
    end
    cyc(1'b1, 4'd12, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd1 || sticky_err !== 1'b1) begin
      failures++;
      $display("FAIL mm_after: err=%b err_cnt=%0d sticky=%b, want 0 1 1", err, err_cnt, sticky_err);
    end
    // A held value is a mismatch too.
    cyc(1'b1, 4'd12, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd2) begin
      failures++; $display("FAIL mm_hold: err=%b err_cnt=%0d, want 1 2", err, err_cnt);
    end
  endtask

  task automatic test_stall();
    logic [3:0] cv [4] = '{4'd5, 4'd9, 4'd9, 4'd6};
    logic       ev [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pulses = 0;
    do_reset();
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b1, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(ev[i], cv[i], 1'b0, 1'b0);
      if (err) pulses++;
    end
    checks++;
    if (pulses !== 0 || locked !== 1'b1 || err_cnt !== 8'd0 || sticky_err !== 1'b0) begin
      failures++;
      $display("FAIL stall: pulses=%0d locked=%b err_cnt=%0d sticky=%b, want 0 1 0 0",
               pulses, locked, err_cnt, sticky_err);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] bad  [5] = '{4'd5, 4'd9, 4'd14, 4'd3, 4'd8};
    int pulses = 0;
    do_reset();
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, bad[i], 1'b0, 1'b0);
      if (err_s) pulses++;
      cyc(1'b1, bad[i] + 4'd1, 1'b0, 1'b0);
      if (err_s) pulses++;
      if (i == 2) begin
        checks++;
        if (err_cnt_s !== 2'd3) begin
          failures++; $display("FAIL sat_reach: got err_cnt=%0d want 3", err_cnt_s);
        end
      end
    end
    checks++;
    if (err_cnt_s !== 2'd3 || pulses !== 5) begin
      failures++;
      $display("FAIL sat_hold: err_cnt=%0d pulses=%0d, want 3 5", err_cnt_s, pulses);
    end
    checks++;
    if (err_cnt !== 8'd5) begin
      failures++; $display("FAIL sat_wide_count: got %0d want 5", err_cnt);
    end
  endtask

  task automatic test_clr();
    do_reset();
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 4'd10, 1'b0, 1'b0);
    checks++;
    if (err_cnt !== 8'd2 || locked !== 1'b1) begin
      failures++; $display("FAIL clr_setup: err_cnt=%0d locked=%b, want 2 1", err_cnt, locked);
    end
    cyc(1'b1, 4'd13, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 8'd1 || sticky_err !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL clr_with_err: err_cnt=%0d sticky=%b err=%b, want 1 1 1", err_cnt, sticky_err, err);
    end
    cyc(1'b1, 4'd14, 1'b0, 1'b0);
    cyc(1'b1, 4'd15, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 8'd0 || sticky_err !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clr_lone: err_cnt=%0d sticky=%b locked=%b, want 0 0 1", err_cnt, sticky_err, locked);
    end
    cyc(1'b1, 4'd0, 1'b1, 1'b0);
    checks++;
    if (wrap_cnt !== 16'd1 || locked !== 1'b1) begin
      failures++; $display("FAIL clr_with_wrap: wrap=%0d locked=%b, want 1 1", wrap_cnt, locked);
    end
  endtask

  task automatic test_rst_mid();
    int pulses = 0;
    do_reset();
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b1, 4'd4, 1'b0, 1'b0);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    cyc(1'b1, 4'd8, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd1 || sticky_err !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_setup: locked=%b err_cnt=%0d sticky=%b, want 1 1 1", locked, err_cnt, sticky_err);
    end
    cyc(1'b1, 4'd10, 1'b0, 1'b1);
    checks++;
    if ({locked, err, sticky_err, err_cnt, wrap_cnt} !== 27'd0) begin
      failures++;
      $display("FAIL rst_mid_clear: locked=%b err=%b sticky=%b err_cnt=%0d wrap=%0d, want all 0",
               locked, err, sticky_err, err_cnt, wrap_cnt);
    end
    cyc(1'b1, 4'd11, 1'b0, 1'b1);
    cyc(1'b1, 4'd12, 1'b0, 1'b0);
    if (err) pulses++;
    checks++;
    if (locked !== 1'b0) begin
      failures++; $display("FAIL rst_mid_acq: locked=%b want 0", locked);
    end
    cyc(1'b1, 4'd13, 1'b0, 1'b0);
    if (err) pulses++;
    checks++;
    if (locked !== 1'b1 || pulses !== 0) begin
      failures++; $display("FAIL rst_mid_relock: locked=%b pulses=%0d, want 1 0", locked, pulses);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; count_in = '0;
    test_reset();
    test_count();
    test_mismatch();
    test_stall();
    test_saturation();
    test_clr();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
